// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder-buffer retire unit.
package rob_pkg;

  // Storage widths of one ROB entry; the top-level PREG_W/DATA_W defaults track these.
  localparam int ROB_PREG_W = 6;
  localparam int ROB_DATA_W = 32;

  // RISC-V STORE major opcode; entries dispatched with this opcode carry is_store=1.
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic                  v;         // entry allocated
    logic                  comp;      // result written back
    logic                  is_store;  // store: no register write at commit
    logic [ROB_PREG_W-1:0] phy;       // destination physical register
    logic [ROB_PREG_W-1:0] old_phy;   // previous mapping, freed at retire
    logic [ROB_DATA_W-1:0] result;    // writeback value
  } rob_entry_t;

  // Index width for a power-of-two depth.
  function automatic int rob_idx_w(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer/count width: one extra bit distinguishes full from empty.
  function automatic int rob_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Consecutive-ready scan from the head of the ROB. Lane r is selected only
// when the entry at head+r is ready and every lower lane is selected too, so
// retirement always stops at the first entry that is not yet complete.
module rob_retire_select import rob_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int RET_W = 2,
  parameter int IDX_W = rob_idx_w(DEPTH),
  parameter int CNT_W = rob_cnt_w(DEPTH)
) (
  input  logic [IDX_W-1:0] head_idx,
  input  logic [DEPTH-1:0] ready_vec,
  output logic [RET_W-1:0] ret_mask,
  output logic [CNT_W-1:0] ret_cnt
);

  logic             run;
  logic [IDX_W-1:0] idx;

  // Walk lanes in order; the first not-ready entry stops all higher lanes.
  always_comb begin
    ret_mask = '0;
    ret_cnt  = '0;
    run      = 1'b1;
    idx      = '0;
    for (int r = 0; r < RET_W; r++) begin
      idx = head_idx + IDX_W'(r);
      if (run && ready_vec[idx]) begin
        ret_mask[r] = 1'b1;
        ret_cnt     = ret_cnt + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_retire_unit.sv
// Reorder buffer with in-order retire. Entries are allocated at the tail by
// dispatch, completed out of order by index-tagged writebacks, and retired
// from the head up to RET_W per cycle. Forward and retire strobes are
// registered, one cycle after the edge that made the decision.
//
// Handshake: a dispatch group transfers on a rising edge where disp_ready=1
// and at least one disp_valid bit is set. disp_ready depends only on the
// current occupancy, never on disp_valid. When disp_ready=0 the whole group
// is ignored and must be presented again. Valid slots are contiguous from
// slot 0. Writeback ports are valid-only and cannot be back-pressured.
module rob_retire_unit import rob_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int DISP_W = 2,
  parameter int NUM_WB = 3,
  parameter int RET_W  = 2,
  parameter int PREG_W = ROB_PREG_W,
  parameter int DATA_W = ROB_DATA_W,
  parameter int IDX_W  = rob_idx_w(DEPTH),
  parameter int CNT_W  = rob_cnt_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [DISP_W-1:0]          disp_valid,
  input  logic [DISP_W*PREG_W-1:0]   disp_phy,
  input  logic [DISP_W*PREG_W-1:0]   disp_old_phy,
  input  logic [DISP_W-1:0]          disp_is_store,
  output logic                       disp_ready,
  output logic [DISP_W*IDX_W-1:0]    disp_idx,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]    wb_idx,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data,
  output logic [NUM_WB-1:0]          fwd_valid,
  output logic [NUM_WB*PREG_W-1:0]   fwd_phy,
  output logic [NUM_WB*DATA_W-1:0]   fwd_data,
  output logic [RET_W-1:0]           rt_valid,
  output logic [RET_W*PREG_W-1:0]    rt_free_phy,
  output logic [RET_W*PREG_W-1:0]    rt_phy,
  output logic [RET_W*DATA_W-1:0]    rt_data,
  output logic [RET_W-1:0]           rt_is_store,
  output logic [CNT_W-1:0]           count,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  rob_entry_t       entries [DEPTH];
  logic [CNT_W-1:0] head;
  logic [CNT_W-1:0] tail;

  logic [CNT_W-1:0] alloc_cnt;
  logic             disp_fire;
  logic [IDX_W-1:0] disp_at    [DISP_W];
  rob_entry_t       disp_entry [DISP_W];

  logic [IDX_W-1:0]  wb_at [NUM_WB];
  logic [NUM_WB-1:0] wb_hit;
  logic [NUM_WB-1:0] wb_miss;

  logic [DEPTH-1:0] ready_vec;
  logic [RET_W-1:0] ret_mask;
  logic [CNT_W-1:0] ret_cnt;
  logic [IDX_W-1:0] ret_at [RET_W];

  // Occupancy status comes straight from the wide pointers.
  assign count      = tail - head;
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign disp_ready = ((CNT_W'(DEPTH) - count) >= CNT_W'(DISP_W));
  assign disp_fire  = disp_ready && (|disp_valid);

  // Slot k targets tail+k; also build the entry each slot would write.
  always_comb begin
    disp_idx   = '0;
    disp_at    = '{default: '0};
    disp_entry = '{default: '0};
    alloc_cnt  = '0;
    for (int k = 0; k < DISP_W; k++) begin
      disp_at[k]                     = tail[IDX_W-1:0] + IDX_W'(k);
      disp_idx[k*IDX_W +: IDX_W]     = disp_at[k];
      disp_entry[k].v                = 1'b1;
      disp_entry[k].comp             = 1'b0;
      disp_entry[k].is_store         = disp_is_store[k];
      disp_entry[k].phy              = disp_phy[k*PREG_W +: PREG_W];
      disp_entry[k].old_phy          = disp_old_phy[k*PREG_W +: PREG_W];
      disp_entry[k].result           = '0;
      alloc_cnt                      = alloc_cnt + CNT_W'(disp_valid[k]);
    end
  end

  // Classify each writeback against the entry state at the start of the cycle.
  always_comb begin
    wb_at   = '{default: '0};
    wb_hit  = '0;
    wb_miss = '0;
    for (int j = 0; j < NUM_WB; j++) begin
      wb_at[j]   = wb_idx[j*IDX_W +: IDX_W];
      wb_hit[j]  = wb_valid[j] &  entries[wb_at[j]].v;
      wb_miss[j] = wb_valid[j] & ~entries[wb_at[j]].v;
    end
  end

  // An entry is retirable once it is allocated and already complete.
  always_comb begin
    ready_vec = '0;
    ret_at    = '{default: '0};
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = entries[i].v & entries[i].comp;
    end
    for (int r = 0; r < RET_W; r++) begin
      ret_at[r] = head[IDX_W-1:0] + IDX_W'(r);
    end
  end

  rob_retire_select #(
    .DEPTH (DEPTH),
    .RET_W (RET_W),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_select (
    .head_idx  (head[IDX_W-1:0]),
    .ready_vec (ready_vec),
    .ret_mask  (ret_mask),
    .ret_cnt   (ret_cnt)
  );

  // Entry storage: writebacks, then allocation, then retire clears (last wins).
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].v    <= 1'b0;
        entries[i].comp <= 1'b0;
      end
    end else begin
      for (int j = 0; j < NUM_WB; j++) begin
        if (wb_hit[j]) begin
          entries[wb_at[j]].comp   <= 1'b1;
          entries[wb_at[j]].result <= wb_data[j*DATA_W +: DATA_W];
        end
      end
      if (disp_fire) begin
        for (int k = 0; k < DISP_W; k++) begin
          if (disp_valid[k]) begin
            entries[disp_at[k]] <= disp_entry[k];
          end
        end
      end
      for (int r = 0; r < RET_W; r++) begin
        if (ret_mask[r]) begin
          entries[ret_at[r]].v    <= 1'b0;
          entries[ret_at[r]].comp <= 1'b0;
        end
      end
    end
  end

  // Head/tail pointers and the sticky error flag; flush leaves err alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      err  <= 1'b0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + ret_cnt;
      if (disp_fire) begin
        tail <= tail + alloc_cnt;
      end
      if (|wb_miss) begin
        err <= 1'b1;
      end
    end
  end

  // Registered forwarding of accepted writebacks to the wakeup logic.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      fwd_valid <= '0;
    end else begin
      fwd_valid <= wb_hit;
      for (int j = 0; j < NUM_WB; j++) begin
        fwd_phy[j*PREG_W +: PREG_W]  <= entries[wb_at[j]].phy;
        fwd_data[j*DATA_W +: DATA_W] <= wb_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Registered commit strobes, lower lanes hold the older entries.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rt_valid <= '0;
    end else begin
      rt_valid <= ret_mask;
      for (int r = 0; r < RET_W; r++) begin
        rt_free_phy[r*PREG_W +: PREG_W] <= entries[ret_at[r]].old_phy;
        rt_phy[r*PREG_W +: PREG_W]      <= entries[ret_at[r]].phy;
        rt_data[r*DATA_W +: DATA_W]     <= entries[ret_at[r]].result;
        rt_is_store[r]                  <= entries[ret_at[r]].is_store;
      end
    end
  end

endmodule

// File: tb/tb_rob_retire_unit.sv
// Testbench for rob_retire_unit: directed scenarios plus a randomized run
// checked against a queue-based model of the reorder buffer.
module tb_rob_retire_unit;

  localparam int DEPTH  = 16;
  localparam int DISP_W = 2;
  localparam int NUM_WB = 3;
  localparam int RET_W  = 2;
  localparam int PREG_W = 6;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                     flush;
  logic [DISP_W-1:0]        disp_valid;
  logic [DISP_W*PREG_W-1:0] disp_phy;
  logic [DISP_W*PREG_W-1:0] disp_old_phy;
  logic [DISP_W-1:0]        disp_is_store;
  logic                     disp_ready;
  logic [DISP_W*IDX_W-1:0]  disp_idx;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*IDX_W-1:0]  wb_idx;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [NUM_WB-1:0]        fwd_valid;
  logic [NUM_WB*PREG_W-1:0] fwd_phy;
  logic [NUM_WB*DATA_W-1:0] fwd_data;
  logic [RET_W-1:0]         rt_valid;
  logic [RET_W*PREG_W-1:0]  rt_free_phy;
  logic [RET_W*PREG_W-1:0]  rt_phy;
  logic [RET_W*DATA_W-1:0]  rt_data;
  logic [RET_W-1:0]         rt_is_store;
  logic [CNT_W-1:0]         count;
  logic                     empty;
  logic                     full;
  logic                     err;

  rob_retire_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .disp_valid   (disp_valid),
    .disp_phy     (disp_phy),
    .disp_old_phy (disp_old_phy),
    .disp_is_store(disp_is_store),
    .disp_ready   (disp_ready),
    .disp_idx     (disp_idx),
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
    .fwd_valid    (fwd_valid),
    .fwd_phy      (fwd_phy),
    .fwd_data     (fwd_data),
    .rt_valid     (rt_valid),
    .rt_free_phy  (rt_free_phy),
    .rt_phy       (rt_phy),
    .rt_data      (rt_data),
    .rt_is_store  (rt_is_store),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .err          (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int               idx;
    int               phy;
    int               old_phy;
    bit               is_store;
    bit               comp;
    logic [DATA_W-1:0] res;
  } m_ent_t;

  m_ent_t            model_q[$];   // oldest entry at the front
  int                m_tail;       // next index to allocate
  bit                m_err;
  logic [DATA_W-1:0] exp_q[$];     // expected rt_data, in retire order

  function automatic int find_pos(input int idx);
    for (int p = 0; p < model_q.size(); p++)
      if (model_q[p].idx == idx) return p;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    flush = 1'b0;
    disp_valid = '0; disp_phy = '0; disp_old_phy = '0; disp_is_store = '0;
    wb_valid = '0; wb_idx = '0; wb_data = '0;
  endtask

  task automatic set_disp(input int k, input int phy, input int old, input bit st);
    disp_valid[k] = 1'b1;
    disp_phy[k*PREG_W +: PREG_W]     = PREG_W'(phy);
    disp_old_phy[k*PREG_W +: PREG_W] = PREG_W'(old);
    disp_is_store[k] = st;
  endtask

  task automatic set_wb(input int j, input int idx, input logic [DATA_W-1:0] d);
    wb_valid[j] = 1'b1;
    wb_idx[j*IDX_W +: IDX_W]    = IDX_W'(idx);
    wb_data[j*DATA_W +: DATA_W] = d;
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    disp_valid = 2'b11;
    clk_step();
    clk_step();
    n_checks++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else n_pass++;
    n_checks++; if (disp_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", disp_ready); else n_pass++;
    n_checks++; if (rt_valid !== 2'b00) $display("FAIL reset_rt_valid got %b exp 00", rt_valid); else n_pass++;
    n_checks++; if (fwd_valid !== 3'b000) $display("FAIL reset_fwd_valid got %b exp 000", fwd_valid); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
    rst_n = 1'b1;
    drive_idle();
  endtask

  task automatic test_dispatch_retire();
    drive_idle();
    set_disp(0, 33, 5, 1'b0);
    set_disp(1, 34, 6, 1'b0);
    n_checks++; if (disp_idx !== 8'h10) $display("FAIL dr_disp_idx got %h exp 10", disp_idx); else n_pass++;
    clk_step();
    drive_idle();
    set_wb(0, 1, 32'hAA);
    set_wb(2, 0, 32'h55);
    n_checks++; if (count !== 5'd2) $display("FAIL dr_count got %0d exp 2", count); else n_pass++;
    clk_step();
    drive_idle();
    n_checks++; if (fwd_valid !== 3'b101) $display("FAIL dr_fwd_valid got %b exp 101", fwd_valid); else n_pass++;
    n_checks++; if (fwd_phy[0 +: 6] !== 6'd34 || fwd_phy[12 +: 6] !== 6'd33)
      $display("FAIL dr_fwd_phy got %h exp p0=34 p2=33", fwd_phy); else n_pass++;
    n_checks++; if (fwd_data[0 +: 32] !== 32'hAA || fwd_data[64 +: 32] !== 32'h55)
      $display("FAIL dr_fwd_data got %h exp p0=aa p2=55", fwd_data); else n_pass++;
    n_checks++; if (rt_valid !== 2'b00) $display("FAIL dr_rt_early got %b exp 00", rt_valid); else n_pass++;
    clk_step();
    n_checks++; if (rt_valid !== 2'b11) $display("FAIL dr_rt_valid got %b exp 11", rt_valid); else n_pass++;
    n_checks++; if (rt_free_phy !== {6'd6, 6'd5}) $display("FAIL dr_rt_free got %h exp 6/5", rt_free_phy); else n_pass++;
    n_checks++; if (rt_phy !== {6'd34, 6'd33}) $display("FAIL dr_rt_phy got %h exp 34/33", rt_phy); else n_pass++;
    n_checks++; if (rt_data !== {32'hAA, 32'h55}) $display("FAIL dr_rt_data got %h exp aa/55", rt_data); else n_pass++;
    n_checks++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL dr_drained got count=%0d empty=%b exp 0/1", count, empty); else n_pass++;
    clk_step();
    n_checks++; if (rt_valid !== 2'b00) $display("FAIL dr_rt_after got %b exp 00", rt_valid); else n_pass++;
  endtask

  task automatic test_out_of_order();
    drive_idle();
    set_disp(0, 40, 7, 1'b0);
    set_disp(1, 41, 8, 1'b1);
    n_checks++; if (disp_idx !== 8'h32) $display("FAIL ooo_disp_idx got %h exp 32", disp_idx); else n_pass++;
    clk_step();
    drive_idle();
    set_wb(1, 3, 32'h33);
    clk_step();
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      clk_step();
      n_checks++; if (rt_valid !== 2'b00) $display("FAIL ooo_no_retire got %b exp 00", rt_valid); else n_pass++;
    end
    n_checks++; if (count !== 5'd2) $display("FAIL ooo_count got %0d exp 2", count); else n_pass++;
    set_wb(0, 2, 32'h22);
    clk_step();
    drive_idle();
    n_checks++; if (rt_valid !== 2'b00) $display("FAIL ooo_same_cycle got %b exp 00", rt_valid); else n_pass++;
    clk_step();
    n_checks++; if (rt_valid !== 2'b11) $display("FAIL ooo_rt_valid got %b exp 11", rt_valid); else n_pass++;
    n_checks++; if (rt_data !== {32'h33, 32'h22}) $display("FAIL ooo_rt_data got %h exp 33/22", rt_data); else n_pass++;
    n_checks++; if (rt_phy !== {6'd41, 6'd40}) $display("FAIL ooo_rt_phy got %h exp 41/40", rt_phy); else n_pass++;
    n_checks++; if (rt_is_store !== 2'b10) $display("FAIL ooo_rt_store got %b exp 10", rt_is_store); else n_pass++;
    clk_step();
  endtask

  task automatic test_full_wrap();
    drive_idle();
    flush = 1'b1;
    clk_step();
    drive_idle();
    for (int i = 0; i < 8; i++) begin
      set_disp(0, 2*i, 10+i, 1'b0);
      set_disp(1, 2*i+1, 30+i, 1'b0);
      clk_step();
      drive_idle();
    end
    n_checks++; if (count !== 5'd16) $display("FAIL fw_count got %0d exp 16", count); else n_pass++;
    n_checks++; if (full !== 1'b1 || disp_ready !== 1'b0) $display("FAIL fw_full got full=%b ready=%b exp 1/0", full, disp_ready); else n_pass++;
    set_disp(0, 60, 1, 1'b0);
    set_disp(1, 61, 2, 1'b0);
    clk_step();
    drive_idle();
    n_checks++; if (count !== 5'd16) $display("FAIL fw_ignored got %0d exp 16", count); else n_pass++;
    set_wb(0, 0, 32'h100);
    set_wb(1, 1, 32'h101);
    clk_step();
    drive_idle();
    clk_step();
    n_checks++; if (rt_valid !== 2'b11) $display("FAIL fw_rt_valid got %b exp 11", rt_valid); else n_pass++;
    n_checks++; if (rt_phy !== {6'd1, 6'd0}) $display("FAIL fw_rt_phy got %h exp 1/0", rt_phy); else n_pass++;
    n_checks++; if (rt_data !== {32'h101, 32'h100}) $display("FAIL fw_rt_data got %h exp 101/100", rt_data); else n_pass++;
    n_checks++; if (count !== 5'd14 || disp_ready !== 1'b1) $display("FAIL fw_after_ret got count=%0d ready=%b exp 14/1", count, disp_ready); else n_pass++;
    set_disp(0, 50, 20, 1'b0);
    set_disp(1, 51, 21, 1'b0);
    n_checks++; if (disp_idx !== 8'h10) $display("FAIL fw_wrap_idx got %h exp 10", disp_idx); else n_pass++;
    clk_step();
    drive_idle();
    n_checks++; if (count !== 5'd16 || full !== 1'b1) $display("FAIL fw_refull got count=%0d full=%b exp 16/1", count, full); else n_pass++;
  endtask

  task automatic test_flush();
    drive_idle();
    flush = 1'b1;
    clk_step();
    drive_idle();
    set_disp(0, 1, 1, 1'b0); set_disp(1, 2, 2, 1'b0); clk_step(); drive_idle();
    set_disp(0, 3, 3, 1'b0); set_disp(1, 4, 4, 1'b0); clk_step(); drive_idle();
    set_disp(0, 5, 5, 1'b0); clk_step(); drive_idle();
    set_wb(0, 0, 32'hF0);
    set_wb(1, 1, 32'hF1);
    clk_step();
    drive_idle();
    n_checks++; if (count !== 5'd5) $display("FAIL fl_pre_count got %0d exp 5", count); else n_pass++;
    flush = 1'b1;
    set_disp(0, 7, 7, 1'b0);
    set_disp(1, 8, 8, 1'b0);
    clk_step();
    drive_idle();
    n_checks++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL fl_count got count=%0d empty=%b exp 0/1", count, empty); else n_pass++;
    n_checks++; if (rt_valid !== 2'b00) $display("FAIL fl_rt_valid got %b exp 00", rt_valid); else n_pass++;
    n_checks++; if (fwd_valid !== 3'b000) $display("FAIL fl_fwd_valid got %b exp 000", fwd_valid); else n_pass++;
    set_disp(0, 9, 9, 1'b0);
    n_checks++; if (disp_idx[0 +: 4] !== 4'd0) $display("FAIL fl_next_idx got %0d exp 0", disp_idx[0 +: 4]); else n_pass++;
    clk_step();
    drive_idle();
    n_checks++; if (count !== 5'd1) $display("FAIL fl_next_count got %0d exp 1", count); else n_pass++;
  endtask

  task automatic test_error();
    drive_idle();
    flush = 1'b1;
    clk_step();
    drive_idle();
    n_checks++; if (err !== 1'b0) $display("FAIL err_clear got %b exp 0", err); else n_pass++;
    set_wb(1, 7, 32'hDEAD);
    clk_step();
    drive_idle();
    n_checks++; if (err !== 1'b1) $display("FAIL err_set got %b exp 1", err); else n_pass++;
    n_checks++; if (fwd_valid !== 3'b000) $display("FAIL err_fwd got %b exp 000", fwd_valid); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL err_count got %0d exp 0", count); else n_pass++;
    flush = 1'b1;
    clk_step();
    drive_idle();
    n_checks++; if (err !== 1'b1) $display("FAIL err_sticky got %b exp 1", err); else n_pass++;
  endtask

  // ---------------- randomized test against the model ----------------
  task automatic test_random();
    logic [NUM_WB-1:0]        e_fv;
    logic [NUM_WB*PREG_W-1:0] e_fphy;
    logic [NUM_WB*DATA_W-1:0] e_fdata;
    logic [RET_W-1:0]         e_rv;
    logic [RET_W*PREG_W-1:0]  e_rfree, e_rphy;
    logic [RET_W-1:0]         e_rst;
    logic [DISP_W*IDX_W-1:0]  e_didx;
    logic [DATA_W-1:0]        e_d;
    bit                       e_ready;
    int                       cand[$];
    int                       hit_pos[NUM_WB];
    int                       nd, n, p, ri;

    rst_n = 1'b0;
    drive_idle();
    clk_step();
    clk_step();
    rst_n = 1'b1;
    model_q.delete();
    exp_q.delete();
    m_tail = 0;
    m_err  = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      drive_idle();
      flush = ($urandom_range(0, 99) < 3);
      ri = $urandom_range(0, 9);
      nd = (ri < 4) ? 2 : (ri < 7) ? 1 : 0;
      for (int k = 0; k < nd; k++)
        set_disp(k, $urandom_range(0, 63), $urandom_range(0, 63), ($urandom_range(0, 3) == 0));
      cand.delete();
      for (int q = 0; q < model_q.size(); q++)
        if (!model_q[q].comp) cand.push_back(q);
      for (int j = 0; j < NUM_WB; j++) begin
        if ($urandom_range(0, 9) < 4) begin
          if (cand.size() > 0 && $urandom_range(0, 19) != 0) begin
            set_wb(j, model_q[cand[$urandom_range(0, cand.size()-1)]].idx, $urandom);
          end else if (disp_valid == '0) begin
            ri = $urandom_range(0, DEPTH-1);
            if (find_pos(ri) < 0) set_wb(j, ri, $urandom);
          end
        end
      end

      // combinational status against the model before the edge
      e_ready = (DEPTH - model_q.size()) >= DISP_W;
      for (int k = 0; k < DISP_W; k++) e_didx[k*IDX_W +: IDX_W] = IDX_W'((m_tail + k) % DEPTH);
      n_checks++; if (count !== CNT_W'(model_q.size())) $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, count, model_q.size()); else n_pass++;
      n_checks++; if (disp_ready !== e_ready) $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, disp_ready, e_ready); else n_pass++;
      n_checks++; if (empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH))
        $display("FAIL rnd_status cyc %0d got empty=%b full=%b size %0d", cyc, empty, full, model_q.size()); else n_pass++;
      n_checks++; if (disp_idx !== e_didx) $display("FAIL rnd_disp_idx cyc %0d got %h exp %h", cyc, disp_idx, e_didx); else n_pass++;

      // model step
      e_fv = '0; e_fphy = '0; e_fdata = '0;
      e_rv = '0; e_rfree = '0; e_rphy = '0; e_rst = '0;
      if (flush) begin
        model_q.delete();
        m_tail = 0;
      end else begin
        n = 0;
        while (n < RET_W && n < model_q.size() && model_q[n].comp) begin
          e_rv[n] = 1'b1;
          e_rfree[n*PREG_W +: PREG_W] = PREG_W'(model_q[n].old_phy);
          e_rphy[n*PREG_W +: PREG_W]  = PREG_W'(model_q[n].phy);
          e_rst[n] = model_q[n].is_store;
          exp_q.push_back(model_q[n].res);
          n++;
        end
        for (int j = 0; j < NUM_WB; j++) begin
          hit_pos[j] = -1;
          if (wb_valid[j]) begin
            p = find_pos(int'(wb_idx[j*IDX_W +: IDX_W]));
            if (p >= 0) begin
              hit_pos[j] = p;
              e_fv[j] = 1'b1;
              e_fphy[j*PREG_W +: PREG_W]  = PREG_W'(model_q[p].phy);
              e_fdata[j*DATA_W +: DATA_W] = wb_data[j*DATA_W +: DATA_W];
            end else begin
              m_err = 1'b1;
            end
          end
        end
        for (int j = 0; j < NUM_WB; j++) begin
          if (hit_pos[j] >= 0) begin
            model_q[hit_pos[j]].comp = 1'b1;
            model_q[hit_pos[j]].res  = wb_data[j*DATA_W +: DATA_W];
          end
        end
        repeat (n) void'(model_q.pop_front());
        if (e_ready && disp_valid != '0) begin
          for (int k = 0; k < DISP_W; k++) begin
            if (disp_valid[k]) begin
              model_q.push_back('{idx: m_tail, phy: int'(disp_phy[k*PREG_W +: PREG_W]),
                                 old_phy: int'(disp_old_phy[k*PREG_W +: PREG_W]),
                                 is_store: disp_is_store[k], comp: 1'b0, res: '0});
              m_tail = (m_tail + 1) % DEPTH;
            end
          end
        end
      end

      clk_step();

      n_checks++; if (fwd_valid !== e_fv) $display("FAIL rnd_fwd_valid cyc %0d got %b exp %b", cyc, fwd_valid, e_fv); else n_pass++;
      for (int j = 0; j < NUM_WB; j++) begin
        if (e_fv[j]) begin
          n_checks++;
          if (fwd_phy[j*PREG_W +: PREG_W] !== e_fphy[j*PREG_W +: PREG_W] || fwd_data[j*DATA_W +: DATA_W] !== e_fdata[j*DATA_W +: DATA_W])
            $display("FAIL rnd_fwd_port%0d cyc %0d got phy=%0d data=%h exp phy=%0d data=%h", j, cyc,
                     fwd_phy[j*PREG_W +: PREG_W], fwd_data[j*DATA_W +: DATA_W], e_fphy[j*PREG_W +: PREG_W], e_fdata[j*DATA_W +: DATA_W]);
          else n_pass++;
        end
      end
      n_checks++; if (rt_valid !== e_rv) $display("FAIL rnd_rt_valid cyc %0d got %b exp %b", cyc, rt_valid, e_rv); else n_pass++;
      for (int r = 0; r < RET_W; r++) begin
        if (e_rv[r]) begin
          e_d = exp_q.pop_front();
          n_checks++;
          if (rt_free_phy[r*PREG_W +: PREG_W] !== e_rfree[r*PREG_W +: PREG_W] || rt_phy[r*PREG_W +: PREG_W] !== e_rphy[r*PREG_W +: PREG_W] ||
              rt_is_store[r] !== e_rst[r] || rt_data[r*DATA_W +: DATA_W] !== e_d)
            $display("FAIL rnd_rt_lane%0d cyc %0d got free=%0d phy=%0d st=%b data=%h exp free=%0d phy=%0d st=%b data=%h", r, cyc,
                     rt_free_phy[r*PREG_W +: PREG_W], rt_phy[r*PREG_W +: PREG_W], rt_is_store[r], rt_data[r*DATA_W +: DATA_W],
                     e_rfree[r*PREG_W +: PREG_W], e_rphy[r*PREG_W +: PREG_W], e_rst[r], e_d);
          else n_pass++;
        end
      end
      n_checks++; if (err !== m_err) $display("FAIL rnd_err cyc %0d got %b exp %b", cyc, err, m_err); else n_pass++;
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_dispatch_retire();
    test_out_of_order();
    test_full_wrap();
    test_flush();
    test_error();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rob_retire_unit.md
Name: rob_retire_unit

Overview:
- Parametrised reorder buffer with in-order retire, placed between dispatch and the register-free/commit logic.
- Circular buffer: DEPTH entries, up to DISP_W allocations, NUM_WB writebacks and RET_W retirements per cycle.
- Writebacks are tagged by ROB index, not by a search on the physical register.
- Adds registered forwarding, full/empty/count status, flush, and a sticky error flag.

Parameters:
DEPTH, 16, ROB entries; power of two, >= 4
DISP_W, 2, dispatch allocations per cycle
NUM_WB, 3, writeback (FU result) ports
RET_W, 2, max retirements per cycle
PREG_W, 6, physical register index width
DATA_W, 32, result width
Derived: IDX_W = log2(DEPTH); CNT_W = IDX_W+1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  discard all entries
disp_valid  in  DISP_W  per-slot allocate request; slot k only if slots 0..k-1 are valid
disp_phy  in  DISP_W*PREG_W  new destination physical reg
disp_old_phy  in  DISP_W*PREG_W  previous mapping, freed at retire
disp_is_store  in  DISP_W  1 = store (opcode 0100011), no reg write
disp_ready  out  1  free slots >= DISP_W
disp_idx  out  DISP_W*IDX_W  index assigned to each slot (combinational from tail)
wb_valid  in  NUM_WB  result valid per FU
wb_idx  in  NUM_WB*IDX_W  ROB index of result
wb_data  in  NUM_WB*DATA_W  result value
fwd_valid  out  NUM_WB  registered forward strobe
fwd_phy  out  NUM_WB*PREG_W  destination phys reg (mark ready)
fwd_data  out  NUM_WB*DATA_W  forwarded result
rt_valid  out  RET_W  retire strobe, registered, lower lanes first
rt_free_phy  out  RET_W*PREG_W  old_phy to return to free list
rt_phy  out  RET_W*PREG_W  committed phys reg
rt_data  out  RET_W*DATA_W  committed result
rt_is_store  out  RET_W  store commit
count  out  CNT_W  occupied entries
empty  out  1  count == 0
full  out  1  count == DEPTH
err  out  1  sticky; writeback to an invalid entry

Behaviour:
- Entry fields: v, comp, is_store, phy, old_phy, result.
- Pointers head/tail are CNT_W wide; the extra bit disambiguates wrap-around. Index = low IDX_W bits; wrap DEPTH-1 -> 0.
- Reset (rst_n=0 at edge): all v/comp=0, head=tail=0. Outputs: count=0, empty=1, full=0, disp_ready=1, err=0, all fwd_valid/rt_valid=0.
- Dispatch is all-or-nothing: accepted only when disp_ready=1.
  - Valid slots are written to tail, tail+1, ... in slot order.
  - Written entries: v=1, comp=0.
  - tail advances by popcount(disp_valid).
  - If disp_valid!=0 while disp_ready=0, the request is ignored and state is unchanged.
- Writeback port j, when wb_valid[j]=1 and v[wb_idx]=1:
  - set result and comp=1 at the edge;
  - next cycle: fwd_valid[j]=1, fwd_phy=entry.phy, fwd_data=wb_data (latency 1).
- Writeback to v=0: dropped, err set, fwd_valid[j]=0.
- Two ports naming the same index in one cycle: the higher port number wins; both still forward.
- A writeback is legal the cycle after its dispatch edge. Same-cycle dispatch+writeback to one index is illegal; the bench must not drive it.
- Retire:
  - Lane r retires head+r iff v=1 and comp=1 and lanes 0..r-1 also retire; stop at the first not-ready entry.
  - Only comp state as of the start of the cycle counts; an entry completed this cycle retires at the earliest next cycle.
  - Retired entries: v=0, comp=0; head advances by the retire count.
  - rt_* is registered and asserted the cycle after the decision.
  - rt_free_phy and rt_phy are driven for stores too; the consumer ignores them when rt_is_store=1.
- Occupancy: count = tail-head (CNT_W arithmetic). Dispatch and retire in the same cycle are both applied; count changes by (alloc - retire).
- Full: dispatch is blocked; retire proceeds. Empty: no retire.
- Flush (synchronous, priority over dispatch, writeback and retire):
  - clears all v/comp; head=tail=0;
  - next-cycle fwd_valid and rt_valid are 0;
  - err is unchanged.
- Reset overrides flush.

Decomposition:
- Shared package rob_pkg: rob_entry_t struct (v, comp, is_store, phy, old_phy, result), OPC_STORE=7'b0100011, clog2-based width helpers.
- One sub-module, rob_retire_select: combinational consecutive-ready scan from head producing the RET_W lane mask and retire count.

Test Plan:
- Reset: hold rst_n=0 2 cycles with disp_valid=2'b11 -> count=0, empty=1, disp_ready=1, no rt_valid/fwd_valid.
- Dispatch and retire:
  - Stimulus: dispatch (phy 33, old 5) and (phy 34, old 6) -> disp_idx 0,1. Next cycle wb port0 idx1 data 0xAA, port2 idx0 data 0x55.
  - Next cycle: fwd_valid=3'b101, fwd_phy 34/33.
  - Following cycle: rt_valid=2'b11, rt_free_phy 5 then 6, rt_data 0x55 then 0xAA.
- Out-of-order: complete idx 1 only -> no retire. Complete idx 0 later -> both retire together, in order.
- Full and wrap: 8 dual dispatches -> full=1, disp_ready=0; a 9th request is ignored. Retire 2, then dispatch 2 -> disp_idx 0,1 (wrap), count=16.
- Flush with 5 entries, 2 complete, and a simultaneous dispatch -> next cycle count=0, empty=1, rt_valid=0. A subsequent dispatch gets idx 0.
- Error: writeback to an empty index 7 -> err=1 (sticky after flush), fwd_valid=0, count unchanged.
